// File: rtl/jump_controller.sv
`timescale 1ns/1ps
// jump_controller: sequences one JAL/JALR at a time through
// execute -> (link writeback) -> PC redirect, or execute -> trap.
module jump_controller #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_is_jalr,
  input  logic [XLEN-1:0]           req_pc,
  input  logic [2:0]                req_funct3,
  input  logic [XLEN-1:0]           req_rs1_value,
  input  logic [XLEN-1:0]           req_immediate,
  input  logic [REG_ADDR_WIDTH-1:0] req_rd,

  output logic                      rd_write_valid,
  input  logic                      rd_write_ready,
  output logic [REG_ADDR_WIDTH-1:0] rd_write_addr,
  output logic [XLEN-1:0]           rd_write_data,

  output logic                      pc_redirect_valid,
  output logic [XLEN-1:0]           pc_redirect_target,
  output logic                      flush,

  output logic                      exception_valid,
  input  logic                      exception_ack,
  output logic [3:0]                exception_cause,
  output logic [XLEN-1:0]           exception_tval,

  output logic                      busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXECUTE,
    S_WRITEBACK,
    S_REDIRECT,
    S_TRAP
  } state_t;

  localparam logic [3:0] CAUSE_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;

  state_t state;
  state_t state_nxt;

  // Latched request operands
  logic                      is_jalr_q;
  logic [XLEN-1:0]           pc_q;
  logic [2:0]                funct3_q;
  logic [XLEN-1:0]           rs1_q;
  logic [XLEN-1:0]           imm_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;

  // Results registered at the end of EXECUTE
  logic [XLEN-1:0]           link_q;
  logic [XLEN-1:0]           target_q;
  logic [3:0]                exc_cause_q;
  logic [XLEN-1:0]           exc_tval_q;

  // Execute-stage arithmetic on latched operands
  logic [XLEN-1:0]           sum_c;
  logic [XLEN-1:0]           target_c;
  logic [XLEN-1:0]           link_c;
  logic                      illegal_c;
  logic                      misaligned_c;

  // Target/link computation and fault detection; all sums wrap mod 2^XLEN
  always_comb begin
    sum_c        = (is_jalr_q ? rs1_q : pc_q) + imm_q;
    target_c     = is_jalr_q ? {sum_c[XLEN-1:1], 1'b0} : sum_c;
    link_c       = pc_q + XLEN'(4);
    illegal_c    = is_jalr_q && (funct3_q != 3'b000);
    misaligned_c = target_c[1];
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; illegal encoding is checked ahead of alignment
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (req_valid) state_nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (illegal_c || misaligned_c) state_nxt = S_TRAP;
        else if (rd_q == '0)           state_nxt = S_REDIRECT;
        else                           state_nxt = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        if (rd_write_ready) state_nxt = S_REDIRECT;
      end
      S_REDIRECT: begin
        state_nxt = S_IDLE;
      end
      S_TRAP: begin
        if (exception_ack) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture the request operands on acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_jalr_q <= 1'b0;
      pc_q      <= '0;
      funct3_q  <= '0;
      rs1_q     <= '0;
      imm_q     <= '0;
      rd_q      <= '0;
    end else if (state == S_IDLE && req_valid) begin
      is_jalr_q <= req_is_jalr;
      pc_q      <= req_pc;
      funct3_q  <= req_funct3;
      rs1_q     <= req_rs1_value;
      imm_q     <= req_immediate;
      rd_q      <= req_rd;
    end
  end

  // Register link, target and exception info during EXECUTE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      link_q      <= '0;
      target_q    <= '0;
      exc_cause_q <= '0;
      exc_tval_q  <= '0;
    end else if (state == S_EXECUTE) begin
      link_q      <= link_c;
      target_q    <= target_c;
      exc_cause_q <= illegal_c ? CAUSE_ILLEGAL : CAUSE_MISALIGNED;
      exc_tval_q  <= illegal_c ? pc_q : target_c;
    end
  end

  // Outputs decoded from state, data qualified so idle outputs read as zero
  always_comb begin
    req_ready          = 1'b0;
    rd_write_valid     = 1'b0;
    rd_write_addr      = '0;
    rd_write_data      = '0;
    pc_redirect_valid  = 1'b0;
    pc_redirect_target = '0;
    flush              = 1'b0;
    exception_valid    = 1'b0;
    exception_cause    = '0;
    exception_tval     = '0;
    busy               = (state != S_IDLE);
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
      end
      S_WRITEBACK: begin
        rd_write_valid = 1'b1;
        rd_write_addr  = rd_q;
        rd_write_data  = link_q;
      end
      S_REDIRECT: begin
        pc_redirect_valid  = 1'b1;
        pc_redirect_target = target_q;
        flush              = 1'b1;
      end
      S_TRAP: begin
        exception_valid = 1'b1;
        exception_cause = exc_cause_q;
        exception_tval  = exc_tval_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_jump_controller.sv
`timescale 1ns/1ps
// Scoreboard bench for jump_controller: stimulus pushes expected write /
// redirect / exception events; a negedge monitor pops and compares them.
module tb_jump_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_jalr;
  logic [31:0] req_pc;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1_value;
  logic [31:0] req_immediate;
  logic [4:0]  req_rd;
  logic        rd_write_valid;
  logic        rd_write_ready;
  logic [4:0]  rd_write_addr;
  logic [31:0] rd_write_data;
  logic        pc_redirect_valid;
  logic [31:0] pc_redirect_target;
  logic        flush;
  logic        exception_valid;
  logic        exception_ack;
  logic [3:0]  exception_cause;
  logic [31:0] exception_tval;
  logic        busy;

  jump_controller #(.XLEN(32), .REG_ADDR_WIDTH(5)) dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_is_jalr        (req_is_jalr),
    .req_pc             (req_pc),
    .req_funct3         (req_funct3),
    .req_rs1_value      (req_rs1_value),
    .req_immediate      (req_immediate),
    .req_rd             (req_rd),
    .rd_write_valid     (rd_write_valid),
    .rd_write_ready     (rd_write_ready),
    .rd_write_addr      (rd_write_addr),
    .rd_write_data      (rd_write_data),
    .pc_redirect_valid  (pc_redirect_valid),
    .pc_redirect_target (pc_redirect_target),
    .flush              (flush),
    .exception_valid    (exception_valid),
    .exception_ack      (exception_ack),
    .exception_cause    (exception_cause),
    .exception_tval     (exception_tval),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int EV_WRITE = 0;
  localparam int EV_REDIR = 1;
  localparam int EV_EXC   = 2;

  typedef struct {
    int          kind;
    logic [31:0] f1;
    logic [31:0] f2;
  } ev_t;

  ev_t sb_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;
  int  write_cyc = -1;
  int  redirect_cyc = -1;
  logic prev_redir = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] f1, input logic [31:0] f2);
    ev_t e;
    e.kind = kind;
    e.f1   = f1;
    e.f2   = f2;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input int kind, input logic [31:0] f1, input logic [31:0] f2);
    ev_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d f1=0x%08h f2=0x%08h expected none", kind, f1, f2);
    end else begin
      e = sb_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk(kind == EV_WRITE ? "write_addr" : kind == EV_REDIR ? "redirect_flags" : "exc_cause", f1, e.f1);
      chk(kind == EV_WRITE ? "write_data" : kind == EV_REDIR ? "redirect_target" : "exc_tval", f2, e.f2);
    end
  endtask

  // Monitor: every handshake / strobe the DUT presents is matched to the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (rd_write_valid && rd_write_ready) begin
        sb_check(EV_WRITE, {27'b0, rd_write_addr}, rd_write_data);
        write_cyc = cyc;
      end
      if (pc_redirect_valid || flush) begin
        if (prev_redir) chk("redirect_one_cycle", {31'b0, prev_redir}, 32'd0);
        sb_check(EV_REDIR, {30'b0, pc_redirect_valid, flush}, pc_redirect_target);
        redirect_cyc = cyc;
      end
      if (exception_valid && exception_ack)
        sb_check(EV_EXC, {28'b0, exception_cause}, exception_tval);
    end
    prev_redir = pc_redirect_valid;
  end

  task automatic issue(input logic jalr, input logic [31:0] pc, input logic [2:0] f3,
                       input logic [31:0] rs1, input logic [31:0] imm, input logic [4:0] rd,
                       output int acc);
    @(negedge clk);
    req_is_jalr   = jalr;
    req_pc        = pc;
    req_funct3    = f3;
    req_rs1_value = rs1;
    req_immediate = imm;
    req_rd        = rd;
    req_valid     = 1'b1;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(output int idle_c);
    idle_c = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready && !busy) begin
        idle_c = cyc;
        break;
      end
    end
    if (idle_c < 0) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_signal_wb(output int ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd_write_valid) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) chk("wb_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_signal_exc(output int ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (exception_valid) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) chk("exc_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_wr_valid"}, {31'b0, rd_write_valid}, 32'd0);
    chk({tag, "_wr_addr"}, {27'b0, rd_write_addr}, 32'd0);
    chk({tag, "_wr_data"}, rd_write_data, 32'd0);
    chk({tag, "_redir_valid"}, {31'b0, pc_redirect_valid}, 32'd0);
    chk({tag, "_redir_target"}, pc_redirect_target, 32'd0);
    chk({tag, "_flush"}, {31'b0, flush}, 32'd0);
    chk({tag, "_exc_valid"}, {31'b0, exception_valid}, 32'd0);
    chk({tag, "_exc_cause"}, {28'b0, exception_cause}, 32'd0);
    chk({tag, "_exc_tval"}, exception_tval, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, idle_c, ok;
    reset          = 1'b1;
    req_valid      = 1'b0;
    req_is_jalr    = 1'b0;
    req_pc         = '0;
    req_funct3     = '0;
    req_rs1_value  = '0;
    req_immediate  = '0;
    req_rd         = '0;
    rd_write_ready = 1'b1;
    exception_ack  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // 1. JAL pc=0x100 imm=0x20 rd=1; exception_ack held high outside TRAP is ignored
    exception_ack = 1'b1;
    push(EV_WRITE, 32'd1, 32'h104);
    push(EV_REDIR, 32'd3, 32'h120);
    issue(1'b0, 32'h100, 3'd0, 32'h0, 32'h20, 5'd1, acc);
    @(negedge clk);
    chk("t1_busy_execute", {31'b0, busy}, 32'd1);
    chk("t1_not_ready_busy", {31'b0, req_ready}, 32'd0);
    wait_idle(idle_c);
    chk("t1_redirect_latency", redirect_cyc - acc, 32'd3);
    chk("t1_next_accept", idle_c - acc, 32'd4);

    // 2. JALR rs1=0x1001 imm=0x10 rd=5, LSB cleared
    push(EV_WRITE, 32'd5, 32'h204);
    push(EV_REDIR, 32'd3, 32'h1010);
    issue(1'b1, 32'h200, 3'd0, 32'h1001, 32'h10, 5'd5, acc);
    wait_idle(idle_c);
    exception_ack = 1'b0;

    // 3. JALR target 0x206 misaligned: cause 0, held until ack
    push(EV_EXC, 32'd0, 32'h206);
    issue(1'b1, 32'h300, 3'd0, 32'h203, 32'h4, 5'd7, acc);
    wait_signal_exc(ok);
    for (int i = 0; i < 3; i++) begin
      chk("t3_exc_held", {31'b0, exception_valid}, 32'd1);
      chk("t3_cause_stable", {28'b0, exception_cause}, 32'd0);
      chk("t3_tval_stable", exception_tval, 32'h206);
      chk("t3_no_write", {31'b0, rd_write_valid}, 32'd0);
      chk("t3_no_redirect", {31'b0, pc_redirect_valid}, 32'd0);
      if (i < 2) @(negedge clk);
    end
    @(posedge clk);
    #1 exception_ack = 1'b1;
    @(posedge clk);
    #1 exception_ack = 1'b0;
    wait_idle(idle_c);

    // 4. Illegal funct3 with misaligned target: illegal wins, tval = pc
    push(EV_EXC, 32'd2, 32'h400);
    issue(1'b1, 32'h400, 3'b001, 32'h203, 32'h0, 5'd9, acc);
    wait_signal_exc(ok);
    @(posedge clk);
    #1 exception_ack = 1'b1;
    @(posedge clk);
    #1 exception_ack = 1'b0;
    wait_idle(idle_c);

    // JAL with misaligned target
    push(EV_EXC, 32'd0, 32'h702);
    issue(1'b0, 32'h700, 3'd0, 32'h0, 32'h2, 5'd4, acc);
    wait_signal_exc(ok);
    @(posedge clk);
    #1 exception_ack = 1'b1;
    @(posedge clk);
    #1 exception_ack = 1'b0;
    wait_idle(idle_c);

    // 5a. JAL rd=0: no write, redirect at N+2, next accept N+3
    push(EV_REDIR, 32'd3, 32'h400);
    issue(1'b0, 32'h500, 3'd0, 32'h0, 32'hFFFF_FF00, 5'd0, acc);
    wait_idle(idle_c);
    chk("t5_rd0_redirect_latency", redirect_cyc - acc, 32'd2);
    chk("t5_rd0_next_accept", idle_c - acc, 32'd3);

    // 5b. rd_write_ready low for 3 cycles: addr/data stable, redirect one cycle after transfer
    rd_write_ready = 1'b0;
    push(EV_WRITE, 32'd31, 32'h604);
    push(EV_REDIR, 32'd3, 32'h640);
    issue(1'b0, 32'h600, 3'd0, 32'h0, 32'h40, 5'd31, acc);
    wait_signal_wb(ok);
    for (int i = 0; i < 3; i++) begin
      chk("t5_wr_valid_held", {31'b0, rd_write_valid}, 32'd1);
      chk("t5_wr_addr_stable", {27'b0, rd_write_addr}, 32'd31);
      chk("t5_wr_data_stable", rd_write_data, 32'h604);
      chk("t5_no_redirect", {31'b0, pc_redirect_valid}, 32'd0);
      if (i < 2) @(negedge clk);
    end
    @(posedge clk);
    #1 rd_write_ready = 1'b1;
    wait_idle(idle_c);
    chk("t5_redirect_after_ready", redirect_cyc - write_cyc, 32'd1);

    // 6. Reset during WRITEBACK drops the pending write and redirect
    rd_write_ready = 1'b0;
    issue(1'b0, 32'h800, 3'd0, 32'h0, 32'h10, 5'd3, acc);
    wait_signal_wb(ok);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    reset = 1'b0;
    rd_write_ready = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", {31'b0, req_ready}, 32'd1);

    // Wrap-around JAL after reset: target 0x4, link 0x0
    push(EV_WRITE, 32'd2, 32'h0);
    push(EV_REDIR, 32'd3, 32'h4);
    issue(1'b0, 32'hFFFF_FFFC, 3'd0, 32'h0, 32'h8, 5'd2, acc);
    wait_idle(idle_c);
    chk("t6_wrap_redirect_latency", redirect_cyc - acc, 32'd3);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
